regfile_wb_arbiter: RTL and testbench

//   Shares the register file's single write port between NREQ writeback sources (ALU, MUL/DIV, LOAD, ...).

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_rr_pick.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package wb_arb_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = 5'd0;
  localparam int unsigned PERF_CW = 16;

  // Index width needed to name n sources.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr is bit 0, take the lowest set bit,
// rotate the winner back to its absolute index.
module wb_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   src;
  logic [IW-1:0]   sel;

  always_comb begin
    rot = '0;
    src = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      src    = IW'((j + 32'(ptr)) % NREQ);
      rot[j] = req[src];
    end
  end

  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (rot[j] && !any) begin
        any = 1'b1;
        sel = IW'(j);
      end
    end
  end

  always_comb begin
    gnt_idx = IW'((32'(sel) + 32'(ptr)) % NREQ);
    gnt     = '0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writeback sources.
// Optional per-source wait counters are built when WB_ARB_PERF_EN is defined.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = RF_DW,
  parameter int unsigned AW   = RF_AW,
  localparam int unsigned IW  = clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    freeze,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*AW-1:0]      req_waddr,
  input  logic [NREQ*DW-1:0]      req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic                    wena,
  output logic [AW-1:0]           waddr,
  output logic [DW-1:0]           wdata,
  output logic [IW-1:0]           grant_id,
  output logic [NREQ*PERF_CW-1:0] perf_wait
);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            wena_q, wena_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any;
  logic            xfer;
  logic [AW-1:0]   sel_waddr;
  logic [DW-1:0]   sel_wdata;

  wb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign req_ready = freeze ? '0 : gnt;
  assign xfer      = any && !freeze;

  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_waddr = req_waddr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Address/data/id hold when idle; a reg-0 write still consumes the slot but never enables.
  always_comb begin
    ptr_d      = ptr_q;
    wena_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    grant_id_d = grant_id_q;
    if (xfer) begin
      ptr_d      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      wena_d     = (sel_waddr != AW'(RF_ZERO_REG));
      waddr_d    = sel_waddr;
      wdata_d    = sel_wdata;
      grant_id_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      wena_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      grant_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wena_q     <= wena_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign wena     = wena_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign grant_id = grant_id_q;

`ifdef WB_ARB_PERF_EN
  logic [NREQ-1:0][PERF_CW-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !req_ready[i] && (perf_q[i] != '1)) begin
        perf_d[i] = perf_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_wait = perf_q;
`else
  assign perf_wait = '0;
`endif

  // A pending request must stay valid until accepted.
  for (genvar i = 0; i < int'(NREQ); i++) begin : g_hold
    a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=4, DW=32, AW=5).
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         freeze;
  logic [3:0]   req_valid;
  logic [19:0]  req_waddr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic         wena;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [1:0]   grant_id;
  logic [63:0]  perf_wait;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .NREQ (4),
    .DW   (32),
    .AW   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (freeze),
    .req_valid (req_valid),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .wena      (wena),
    .waddr     (waddr),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .perf_wait (perf_wait)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
    req_waddr[i*5 +: 5]   = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  // Inputs are cleared while reset is held so no pending request is abandoned live.
  task automatic do_reset();
    rst_n     = 1'b0;
    freeze    = 1'b0;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wena !== 1'b0) begin errors++; $display("FAIL rst_wena got %b exp 0", wena); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid got %0d exp 0", grant_id); end
    checks++; if (perf_wait !== 64'd0) begin errors++; $display("FAIL rst_perf got %h exp 0", perf_wait); end
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 32'hA0 + 32'(i));
    req_valid = 4'b1111;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_pre_ready got %b exp 0100", req_ready); end
    checks++; if (wena !== 1'b1) begin errors++; $display("FAIL rst_pre_wena got %b exp 1", wena); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wena !== 1'b0) begin errors++; $display("FAIL rst_async_wena got %b exp 0", wena); end
    checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL rst_async_waddr got %0d exp 0", waddr); end
    checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL rst_async_wdata got %h exp 0", wdata); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_async_gid got %0d exp 0", grant_id); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_async_ptr got %b exp 0001", req_ready); end
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_first_gid got %0d exp 0", grant_id); end
    checks++; if (wena !== 1'b1 || waddr !== 5'd1) begin errors++; $display("FAIL rst_first_wr got %b/%0d exp 1/1", wena, waddr); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 32'hA0 + 32'(i));
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_ready0 got %b exp 0001", req_ready); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (grant_id !== 2'(c % 4)) begin errors++; $display("FAIL rr_gid[%0d] got %0d exp %0d", c, grant_id, c % 4); end
      checks++; if (wena !== 1'b1) begin errors++; $display("FAIL rr_wena[%0d] got %b exp 1", c, wena); end
      checks++; if (waddr !== 5'(c % 4 + 1)) begin errors++; $display("FAIL rr_waddr[%0d] got %0d exp %0d", c, waddr, c % 4 + 1); end
      checks++; if (wdata !== 32'hA0 + 32'(c % 4)) begin errors++; $display("FAIL rr_wdata[%0d] got %h exp %h", c, wdata, 32'hA0 + 32'(c % 4)); end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_src(2, 5'd7, 32'h1234);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (wena !== 1'b1) begin errors++; $display("FAIL single_wena got %b exp 1", wena); end
    checks++; if (waddr !== 5'd7) begin errors++; $display("FAIL single_waddr got %0d exp 7", waddr); end
    checks++; if (wdata !== 32'h1234) begin errors++; $display("FAIL single_wdata got %h exp 1234", wdata); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid got %0d exp 2", grant_id); end
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (wena !== 1'b0) begin errors++; $display("FAIL idle_wena got %b exp 0", wena); end
    checks++; if (waddr !== 5'd7 || wdata !== 32'h1234 || grant_id !== 2'd2) begin
      errors++; $display("FAIL idle_hold got %0d/%h/%0d exp 7/1234/2", waddr, wdata, grant_id); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_src(1, 5'd0, 32'h55);
    set_src(3, 5'd9, 32'h99);
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_ready1 got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b1000;
    checks++; if (wena !== 1'b0) begin errors++; $display("FAIL zero_wena got %b exp 0", wena); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL zero_gid got %0d exp 1", grant_id); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL zero_ready3 got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (wena !== 1'b1 || waddr !== 5'd9) begin errors++; $display("FAIL zero_next_wr got %b/%0d exp 1/9", wena, waddr); end
    checks++; if (wdata !== 32'h99 || grant_id !== 2'd3) begin errors++; $display("FAIL zero_next_data got %h/%0d exp 99/3", wdata, grant_id); end
  endtask

  task automatic test_freeze();
    do_reset();
    set_src(0, 5'd4, 32'hF0);
    set_src(1, 5'd5, 32'hF1);
    freeze    = 1'b1;
    req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL frz_ready[%0d] got %b exp 0000", c, req_ready); end
      tick();
      checks++; if (wena !== 1'b0) begin errors++; $display("FAIL frz_wena[%0d] got %b exp 0", c, wena); end
    end
    freeze = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL frz_ptr got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    checks++; if (grant_id !== 2'd0 || waddr !== 5'd4 || wena !== 1'b1) begin
      errors++; $display("FAIL frz_first got %0d/%0d/%b exp 0/4/1", grant_id, waddr, wena); end
    tick();
    req_valid = 4'b0000;
    checks++; if (grant_id !== 2'd1 || wdata !== 32'hF1) begin
      errors++; $display("FAIL frz_second got %0d/%h exp 1/f1", grant_id, wdata); end
  endtask

`ifdef WB_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 10), 32'hC0 + 32'(i));
    freeze    = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    freeze = 1'b0;
    tick();
    req_valid = 4'b1110;
    tick();
    req_valid = 4'b1100;
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    checks++; if (perf_wait[63:48] !== 16'd5) begin errors++; $display("FAIL perf_src3 got %0d exp 5", perf_wait[63:48]); end
    checks++; if (perf_wait[47:0] !== {16'd4, 16'd3, 16'd2}) begin
      errors++; $display("FAIL perf_src012 got %h exp 000400030002", perf_wait[47:0]); end
    do_reset();
    freeze    = 1'b1;
    req_valid = 4'b1000;
    repeat (65540) tick();
    checks++; if (perf_wait[63:48] !== 16'hFFFF) begin errors++; $display("FAIL perf_sat got %h exp ffff", perf_wait[63:48]); end
    checks++; if (perf_wait[47:0] !== 48'd0) begin errors++; $display("FAIL perf_sat_others got %h exp 0", perf_wait[47:0]); end
  endtask
`else
  task automatic test_perf();
    do_reset();
    freeze    = 1'b1;
    req_valid = 4'b1000;
    repeat (5) tick();
    checks++; if (perf_wait !== 64'd0) begin errors++; $display("FAIL perf_off got %h exp 0", perf_wait); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    freeze    = 1'b0;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_zero_reg();
    test_freeze();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
